// File: rtl/tb_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, start/data/stop sampling FSM, and a small
// valid/ready FIFO with framing-error and overrun pulses.
module tb_uart_rx #(
  parameter int clk_freq       = 100000000,
  parameter int uart_baud_rate = 1152000,
  parameter int fifo_depth     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int divisor = clk_freq / uart_baud_rate;
  localparam int half    = divisor / 2;
  localparam int cnt_w   = $clog2(divisor);
  localparam int ptr_w   = $clog2(fifo_depth);

  localparam logic [cnt_w-1:0] half_m1    = cnt_w'(half - 1);
  localparam logic [cnt_w-1:0] divisor_m1 = cnt_w'(divisor - 1);
  localparam logic [ptr_w:0]   fifo_full  = (ptr_w + 1)'(fifo_depth);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  logic             sync1_q, sync1_d;
  logic             rxd_s_q, rxd_s_d;
  logic             rxd_d_q, rxd_d_d;
  logic [2:0]       state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       mem_q [fifo_depth];
  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_w:0]   count_q, count_d;

  logic push, pop, full, wr_en, cnt_zero;

  always_comb begin
    sync1_d     = uart_rxd;
    rxd_s_d     = sync1_q;
    rxd_d_d     = rxd_s_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    cnt_zero    = (cnt_q == '0);
    case (state_q)
      ST_IDLE: begin
        if (rxd_d_q && !rxd_s_q) begin
          cnt_d   = half_m1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxd_s_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d     = divisor_m1;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rxd_s_q, shift_q[7:1]};
          cnt_d   = divisor_m1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxd_s_q) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (rxd_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
  always_comb begin
    pop       = rx_valid && rx_ready;
    full      = (count_q == fifo_full);
    wr_en     = push && (!full || pop);
    overrun_d = push && full && !pop;
    wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    if (wr_en && !pop) count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      rxd_s_q     <= 1'b1;
      rxd_d_q     <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < fifo_depth; i++) mem_q[i] <= '0;
    end else begin
      sync1_q     <= sync1_d;
      rxd_s_q     <= rxd_s_d;
      rxd_d_q     <= rxd_d_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign rx_data   = mem_q[rd_ptr_q];
  assign rx_valid  = (count_q != '0);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/tb_uart_rx.md
# tb_uart_rx

Serial receiver that consumes the `uart_txd` line driven by the `system` top level and turns it back into bytes for the simulation bench and on-board loopback checks. It samples 8N1 frames at the configured baud rate, buffers received bytes in a small FIFO with a valid/ready output, and flags framing errors and overruns. It sits directly downstream of the SoC UART transmitter, as the communication partner in the system-level bench.

## Interface

Parameters:
- `clk_freq`, 100000000, clock frequency in Hz.
- `uart_baud_rate`, 1152000, line rate in bit/s.
- `fifo_depth`, 4, receive FIFO entries; a power of two, minimum 2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `uart_rxd`  in  1  serial input, connected to the DUT `uart_txd`; idles high.
- `rx_data`  out  8  byte at the FIFO head.
- `rx_valid`  out  1  FIFO is not empty.
- `rx_ready`  in  1  consumer accepts the head byte.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- `busy`  out  1  high while the FSM is outside IDLE.

## Operation

- **Derived constants:** `divisor = clk_freq / uart_baud_rate` (integer division). `half = divisor / 2`. With the defaults, divisor = 86 and half = 43. The baud counter is `$clog2(divisor)` bits wide and counts down to 0.
- **Synchronizer:** `uart_rxd` passes through two flops, both reset to 1. All logic uses the second flop output, `rxd_s`. Start detection also uses a third flop, `rxd_d`, which holds the previous `rxd_s`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - **IDLE:** When `rxd_d`=1 and `rxd_s`=0 (falling edge), load the counter with `half-1` and go to START.
  - **START:** When the counter reaches 0, sample `rxd_s`.
    - If `rxd_s`=1, this is a false start: return to IDLE and push nothing.
    - If `rxd_s`=0, reload `divisor-1`, clear the bit index, and go to DATA.
  - **DATA:** Each time the counter reaches 0, shift `rxd_s` into the shift register LSB-first and reload `divisor-1`. After bit index 7, go to STOP.
  - **STOP:** When the counter reaches 0, sample `rxd_s`.
    - If 1: push the byte to the FIFO and go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
  - **WAIT_HIGH:** Stay until `rxd_s`=1, then go to IDLE. A break condition therefore yields exactly one `frame_err`.
- **FIFO:**
  - Circular buffer with `fifo_depth` entries, read/write pointers, and a count.
  - A pop occurs when `rx_valid && rx_ready`.
  - A push into a full FIFO with no simultaneous pop drops the new byte and pulses `overrun`. Contents are unchanged.
  - A push and a pop in the same cycle when full: both occur, count is unchanged, and there is no overrun.
  - A push and a pop in the same cycle when count is 1: both occur, and `rx_valid` stays high.
  - Pointers wrap modulo `fifo_depth`.
  - `rx_data` shows the head entry combinationally from storage. It is held stable while `rx_valid`=1 and `rx_ready`=0.

## Timing

- **Reset values:** `rx_valid`=0, `rx_data`=0x00, `frame_err`=0, `overrun`=0, `busy`=0, FSM in IDLE, FIFO empty, synchronizer flops at 1.
- **Reset mid-frame:** Asserting reset during a frame aborts it immediately, with no push and no flags. The next falling edge after release starts a fresh frame.
- **Detect latency:** A line falling edge appears on `rxd_s` 2 cycles later. The FSM enters START on the following edge.
- **Sample points (cycles after entering START):**
  - Start bit: `half`.
  - Data bit n: `half + (n+1)·divisor`.
  - Stop bit: `half + 9·divisor`.
- **Output latency:**
  - `rx_valid` rises 1 cycle after the stop-bit sample when the FIFO was empty.
  - `frame_err` and `overrun` are high during that same cycle only.
- **`busy`:** High from the cycle after leaving IDLE until the cycle the FSM re-enters IDLE.
- **Back-to-back frames:** The FSM returns to IDLE at the mid-stop-bit sample. It is therefore armed for the next start edge about half a bit early, so back-to-back frames are received with no gap.
- **Pop timing:** A pop updates `rx_data` and `rx_valid` on the next clock edge.

## Test plan

All tests use default parameters (divisor 86) and drive `uart_rxd` at 86 clocks per bit.

1. **Single byte:** Send 0x55 with `rx_ready`=1 → `rx_valid` high for exactly 1 cycle with `rx_data`=0x55, 1 cycle after the stop sample. `frame_err`=0, `overrun`=0, and `busy` falls back to 0.
2. **Glitch rejection:** Drive a low glitch of 20 clocks on an idle line → no push, no `frame_err`; `busy` pulses high then returns to 0 before the START sample completes. Then send 0x3C → received as 0x3C.
3. **Framing error:** Send 0xA5 with the stop bit low, then hold the line low for 3 bit times → exactly one `frame_err` pulse, `rx_valid` stays 0. After the line goes high, send 0x5A → received correctly.
4. **Fill and overrun:** With `rx_ready`=0, send 0x01..0x05 back to back → `rx_valid` is high after the first byte, one `overrun` pulse occurs at the fifth stop sample, and popping yields 0x01, 0x02, 0x03, 0x04, then `rx_valid`=0.
5. **Full with simultaneous pop:** With the FIFO full, pulse `rx_ready` for 1 cycle aligned with the push of 0x66 → no overrun, and the final pop order ends with 0x66.
6. **Reset mid-frame:** Assert `rst` for 3 cycles at data bit 4 of 0xC3 → all outputs return to reset values immediately and nothing is pushed. Then send 0x00 followed directly by 0xFF → both are received in order.
